// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet ingress parser slice.
//   state_t      parser FSM states
//   DEF_*        default destination/source address tables (entry 0 in the low word)
//   pkt_word_t   FIFO word layout {eop, sop, data} at the default data width
//   csum_f       running XOR checksum step, wide enough for any supported DATA_WIDTH
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRC,
        ST_PAYLOAD,
        ST_EMIT,
        ST_DROP
    } state_t;

    localparam int          DEF_DATA_WIDTH = 32;
    localparam logic [63:0] DEF_PORT_ADDR  = {32'h0000EFEF, 32'h0000ABCD};
    localparam logic [63:0] DEF_SRC_ADDR   = {32'h00004567, 32'h00000123};

    // Checksum operands are zero-extended to this width and truncated back by the caller.
    localparam int CSUM_MAX_W = 128;

    typedef struct packed {
        logic                      eop;
        logic                      sop;
        logic [DEF_DATA_WIDTH-1:0] data;
    } pkt_word_t;

    function automatic logic [CSUM_MAX_W-1:0] csum_f(input logic [CSUM_MAX_W-1:0] acc,
                                                     input logic [CSUM_MAX_W-1:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/eth_pkt_buf.sv
// Packet store: MAX_WORDS x DATA_WIDTH, one write and one read port.
//   clr      restart both pointers; a write in the same cycle lands at address 0
//   wr_en    store wr_data at the current write pointer
//   rd_en    advance the read pointer
//   rd_data  word at the read pointer (combinational)
//   count    words stored so far
//   rd_idx   read pointer
//   full     MAX_WORDS stored; another write would overflow
module eth_pkt_buf
    import eth_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_WORDS  = 16,
    localparam int AW         = $clog2(MAX_WORDS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [AW:0]           count,
    output logic [AW:0]           rd_idx,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [MAX_WORDS];
    logic [AW-1:0]         wr_addr;

    assign wr_addr = clr ? '0 : count[AW-1:0];
    assign rd_data = mem[rd_idx[AW-1:0]];
    assign full    = (count == (AW+1)'(MAX_WORDS));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= '0;
            rd_idx <= '0;
        end else if (clr) begin
            count  <= (AW+1)'(wr_en);
            rd_idx <= '0;
        end else begin
            count  <= count + (AW+1)'(wr_en);
            rd_idx <= rd_idx + (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/eth_rx_parser.sv
// Ingress parser: validates dest/src of an incoming word stream, buffers the packet,
// then writes it plus a trailing XOR checksum word into the destination port FIFO.
//   clk, rstn            clock, asynchronous active-low reset
//   indata/in_valid      input word and qualifier; insop/ineop mark first/last word
//   in_ready             word accepted when in_valid & in_ready (low only while emitting)
//   fifo_full            per-port FIFO full; stalls emission
//   out_wr_en/out_port   write strobe and target FIFO index
//   out_data             {eop, sop, word}
//   pkt_cnt/drop_cnt     saturating packet-written / packet-dropped counters
module eth_rx_parser
    import eth_pkg::*;
#(
    parameter int                              DATA_WIDTH = 32,
    parameter int                              NUM_PORTS  = 2,
    parameter int                              MAX_WORDS  = 16,
    parameter logic [NUM_PORTS*DATA_WIDTH-1:0] PORT_ADDR  = DEF_PORT_ADDR,
    parameter int                              NUM_SRC    = 2,
    parameter logic [NUM_SRC*DATA_WIDTH-1:0]   SRC_ADDR   = DEF_SRC_ADDR,
    parameter int                              CNT_WIDTH  = 16,
    localparam int                             PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int                             AW         = $clog2(MAX_WORDS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] indata,
    input  logic                  in_valid,
    input  logic                  insop,
    input  logic                  ineop,
    output logic                  in_ready,
    input  logic [NUM_PORTS-1:0]  fifo_full,
    output logic                  out_wr_en,
    output logic [PW-1:0]         out_port,
    output logic [DATA_WIDTH+1:0] out_data,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0]           inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(inc);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] csum, csum_n, csum_upd;
    logic [PW-1:0]         port_n, dest_idx;
    logic                  dest_hit, src_hit, accept, at_csum;
    logic                  buf_wr, buf_clr, buf_rd, buf_full, pkt_inc;
    logic [1:0]            drop_add;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic [AW:0]           buf_count, buf_rd_idx;

    eth_pkt_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_WORDS  (MAX_WORDS)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (indata),
        .rd_en   (buf_rd),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .rd_idx  (buf_rd_idx),
        .full    (buf_full)
    );

    assign in_ready = (state != ST_EMIT);
    assign accept   = in_valid && in_ready;
    assign csum_upd = DATA_WIDTH'(csum_f(CSUM_MAX_W'(csum), CSUM_MAX_W'(indata)));
    // The read pointer reaching the stored word count means the checksum slot is next.
    assign at_csum  = (buf_rd_idx == buf_count);

    always_comb begin
        dest_hit = 1'b0;
        dest_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!dest_hit && indata == PORT_ADDR[i*DATA_WIDTH +: DATA_WIDTH]) begin
                dest_hit = 1'b1;
                dest_idx = PW'(i);
            end
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (indata == SRC_ADDR[i*DATA_WIDTH +: DATA_WIDTH]) begin
                src_hit = 1'b1;
            end
        end
    end

    always_comb begin
        out_wr_en = (state == ST_EMIT) && !fifo_full[out_port];
        out_data  = '0;
        if (state == ST_EMIT) begin
            if (at_csum) begin
                out_data = {1'b1, 1'b0, csum};
            end else begin
                out_data = {1'b0, (buf_rd_idx == '0), buf_rd_data};
            end
        end
    end

    always_comb begin
        state_n  = state;
        csum_n   = csum;
        port_n   = out_port;
        buf_wr   = 1'b0;
        buf_clr  = 1'b0;
        buf_rd   = 1'b0;
        drop_add = 2'd0;
        pkt_inc  = 1'b0;
        if (accept && insop) begin
            // A sop always restarts parsing; an unfinished good packet counts as dropped.
            if (state == ST_SRC || state == ST_PAYLOAD) begin
                drop_add = 2'd1;
            end
            if (dest_hit && !ineop) begin
                buf_clr = 1'b1;
                buf_wr  = 1'b1;
                port_n  = dest_idx;
                csum_n  = indata;
                state_n = ST_SRC;
            end else begin
                // Unknown destination, or a one-word runt.
                drop_add = drop_add + 2'd1;
                state_n  = ineop ? ST_IDLE : ST_DROP;
            end
        end else begin
            case (state)
                ST_IDLE: ;
                ST_SRC: begin
                    if (accept) begin
                        if (ineop) begin
                            drop_add = 2'd1;
                            state_n  = ST_IDLE;
                        end else if (src_hit) begin
                            buf_wr  = 1'b1;
                            csum_n  = csum_upd;
                            state_n = ST_PAYLOAD;
                        end else begin
                            drop_add = 2'd1;
                            state_n  = ST_DROP;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        if (buf_full) begin
                            drop_add = 2'd1;
                            state_n  = ineop ? ST_IDLE : ST_DROP;
                        end else begin
                            buf_wr  = 1'b1;
                            csum_n  = csum_upd;
                            state_n = ineop ? ST_EMIT : ST_PAYLOAD;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_wr_en) begin
                        buf_rd = 1'b1;
                        if (at_csum) begin
                            pkt_inc = 1'b1;
                            buf_clr = 1'b1;
                            csum_n  = '0;
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && ineop) begin
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            csum     <= '0;
            out_port <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            csum     <= csum_n;
            out_port <= port_n;
            pkt_cnt  <= sat_add(pkt_cnt, {1'b0, pkt_inc});
            drop_cnt <= sat_add(drop_cnt, drop_add);
        end
    end

endmodule

// File: tb/tb_eth_rx_parser.sv
module tb_eth_rx_parser;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] indata;
    logic        in_valid, insop, ineop;
    logic        in_ready;
    logic [1:0]  fifo_full;
    logic        out_wr_en;
    logic        out_port;
    logic [33:0] out_data;
    logic [15:0] pkt_cnt, drop_cnt;

    eth_rx_parser dut (
        .clk       (clk),
        .rstn      (rstn),
        .indata    (indata),
        .in_valid  (in_valid),
        .insop     (insop),
        .ineop     (ineop),
        .in_ready  (in_ready),
        .fifo_full (fifo_full),
        .out_wr_en (out_wr_en),
        .out_port  (out_port),
        .out_data  (out_data),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // FIFO write log {port, eop, sop, word}, plus count of not-ready cycles.
    logic [34:0] wlog [0:1023];
    int          wcnt = 0;
    int          busy = 0;

    always @(negedge clk) begin
        if (rstn && out_wr_en) begin
            wlog[wcnt] <= {out_port, out_data};
            wcnt       <= wcnt + 1;
        end
        if (rstn && !in_ready) begin
            busy <= busy + 1;
        end
    end

    logic [34:0] exp_log [0:1023];
    int          ecnt  = 0;
    int          chk_i = 0;
    int          nvec  = 0;
    int          nerr  = 0;
    logic [31:0] pw [0:31];
    int          plen;
    int          busy0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic s, input logic e);
        int n;
        n        = 0;
        indata   = d;
        insop    = s;
        ineop    = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk_val("put_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        insop    = 1'b0;
        ineop    = 1'b0;
    endtask

    task automatic send_pkt(input int gap);
        for (int i = 0; i < plen; i++) begin
            put(pw[i], (i == 0), (i == plen - 1));
            if (gap > 0) idle(i % (gap + 1));
        end
    endtask

    task automatic expect_pkt(input logic p);
        logic [31:0] cs;
        cs = '0;
        for (int i = 0; i < plen; i++) begin
            cs = cs ^ pw[i];
            exp_log[ecnt] = {p, 1'b0, (i == 0), pw[i]};
            ecnt++;
        end
        exp_log[ecnt] = {p, 1'b1, 1'b0, cs};
        ecnt++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (wcnt < ecnt && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        idle(3);
        chk_val("write_count", 64'(wcnt), 64'(ecnt));
        for (int i = chk_i; i < ecnt && i < wcnt; i++) begin
            chk_val($sformatf("word%0d", i), 64'(wlog[i]), 64'(exp_log[i]));
        end
        chk_i = ecnt;
    endtask

    task automatic resync();
        ecnt  = wcnt;
        chk_i = wcnt;
    endtask

    initial begin
        rstn      = 1'b0;
        indata    = '0;
        in_valid  = 1'b0;
        insop     = 1'b0;
        ineop     = 1'b0;
        fifo_full = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_wr_en", 64'(out_wr_en), 64'd0);
        chk_val("rst_data", 64'(out_data), 64'd0);
        chk_val("rst_port", 64'(out_port), 64'd0);
        chk_val("rst_ready", 64'(in_ready), 64'd1);
        chk_val("rst_cnts", {pkt_cnt, drop_cnt}, 64'd0);
        rstn = 1'b1;
        idle(1);

        // Word without sop in IDLE is ignored.
        put(32'h999, 1'b0, 1'b0);
        idle(3);
        chk_val("nosop_writes", 64'(wcnt), 64'd0);
        chk_val("nosop_drop", 64'(drop_cnt), 64'd0);

        // 1: basic packet to port 0.
        pw[0] = 32'hABCD; pw[1] = 32'h0123; pw[2] = 32'h11; pw[3] = 32'h22; plen = 4;
        send_pkt(0);
        expect_pkt(1'b0);
        drain();
        chk_val("t1_csum", 64'(wlog[ecnt-1]), {29'd0, 3'b010, 32'h0000AADD});
        chk_val("t1_pkt", 64'(pkt_cnt), 64'd1);

        // 2: backpressure on port 1 for 5 cycles.
        fifo_full = 2'b10;
        pw[0] = 32'hEFEF; pw[1] = 32'h4567; pw[2] = 32'h55; plen = 3;
        send_pkt(0);
        repeat (5) begin
            @(negedge clk);
            chk_val("t2_stall_wr", 64'(out_wr_en), 64'd0);
        end
        chk_val("t2_held", 64'(out_data), {30'd0, 2'b01, 32'h0000EFEF});
        chk_val("t2_port", 64'(out_port), 64'd1);
        @(posedge clk);
        #1;
        fifo_full = 2'b00;
        expect_pkt(1'b1);
        drain();
        chk_val("t2_csum", 64'(wlog[ecnt-1]), {29'd0, 3'b110, 32'h0000AADD});
        chk_val("t2_pkt", 64'(pkt_cnt), 64'd2);

        // 3: unknown destination dropped, next good packet passes.
        pw[0] = 32'h1234; pw[1] = 32'h4567; pw[2] = 32'h1; pw[3] = 32'h2; pw[4] = 32'h3; plen = 5;
        send_pkt(0);
        idle(4);
        chk_val("t3_nowrite", 64'(wcnt), 64'(ecnt));
        chk_val("t3_drop", 64'(drop_cnt), 64'd1);
        pw[0] = 32'hABCD; pw[1] = 32'h0123; pw[2] = 32'h33; plen = 3;
        send_pkt(0);
        expect_pkt(1'b0);
        drain();
        chk_val("t3_pkt", 64'(pkt_cnt), 64'd3);

        // 4: 17-word overflow, 16-word maximum, dest+src runt.
        pw[0] = 32'hABCD; pw[1] = 32'h0123;
        for (int i = 2; i < 17; i++) pw[i] = 32'h100 + 32'(i);
        plen = 17;
        send_pkt(0);
        idle(4);
        chk_val("t4_ovf_nowrite", 64'(wcnt), 64'(ecnt));
        chk_val("t4_ovf_drop", 64'(drop_cnt), 64'd2);
        plen = 16;
        send_pkt(0);
        expect_pkt(1'b0);
        drain();
        chk_val("t4_max_pkt", 64'(pkt_cnt), 64'd4);
        pw[0] = 32'hABCD; pw[1] = 32'h0123; plen = 2;
        send_pkt(0);
        idle(4);
        chk_val("t4_runt_nowrite", 64'(wcnt), 64'(ecnt));
        chk_val("t4_runt_drop", 64'(drop_cnt), 64'd3);

        // 5: sop in the middle of a payload aborts the first packet.
        put(32'hABCD, 1'b1, 1'b0);
        put(32'h0123, 1'b0, 1'b0);
        put(32'h44, 1'b0, 1'b0);
        pw[0] = 32'hEFEF; pw[1] = 32'h4567; pw[2] = 32'h66; plen = 3;
        send_pkt(0);
        expect_pkt(1'b1);
        drain();
        chk_val("t5_csum", 64'(wlog[ecnt-1]), {29'd0, 3'b110, 32'h0000AAEE});
        chk_val("t5_drop", 64'(drop_cnt), 64'd4);
        chk_val("t5_pkt", 64'(pkt_cnt), 64'd5);

        // 5b: reset pulse while emitting.
        pw[0] = 32'hEFEF; pw[1] = 32'h4567; pw[2] = 32'h77; pw[3] = 32'h88; plen = 4;
        send_pkt(0);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_val("t5_rst_wr", 64'(out_wr_en), 64'd0);
        chk_val("t5_rst_data", 64'(out_data), 64'd0);
        chk_val("t5_rst_port", 64'(out_port), 64'd0);
        chk_val("t5_rst_cnts", {pkt_cnt, drop_cnt}, 64'd0);
        chk_val("t5_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
        resync();

        // 6: back-to-back packets with input gaps.
        busy0 = busy;
        pw[0] = 32'hABCD; pw[1] = 32'h0123; pw[2] = 32'h1; pw[3] = 32'h2; plen = 4;
        expect_pkt(1'b0);
        send_pkt(2);
        pw[0] = 32'hEFEF; pw[1] = 32'h4567; pw[2] = 32'h3; plen = 3;
        expect_pkt(1'b1);
        send_pkt(1);
        drain();
        chk_val("t6_busy_cycles", 64'(busy - busy0), 64'd9);
        chk_val("t6_pkt", 64'(pkt_cnt), 64'd2);
        chk_val("t6_drop", 64'(drop_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
